ts_sync_ctrl: RTL and testbench

TS_SYNC_CTRL -- requirements
Module: ts_sync_ctrl

---
 rtl/ts_pkg.sv | 14 +
 rtl/ts_cc_checker.sv | 47 ++++
 rtl/ts_sync_ctrl.sv | 154 +++++++++++++++
 tb/tb_ts_sync_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// Shared constants and FSM state type for the MPEG-TS sync controller.
package ts_pkg;

  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
  localparam int          TS_PKT_LEN   = 188;
  localparam logic [12:0] TS_NULL_PID  = 13'h1FFF;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } ts_state_e;

endpackage

// File: rtl/ts_cc_checker.sv
// Continuity-counter checker for one monitored PID; built only with TS_CC_CHECK_EN.
module ts_cc_checker
  import ts_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        hdr_stb,
  input  logic [12:0] pid,
  input  logic [3:0]  cc,
  input  logic        afc_payload,
  input  logic [12:0] target_pid,
  output logic        cc_err,
  output logic [15:0] cc_err_cnt
);

  logic       seeded;
  logic [3:0] last_cc;
  logic       qualify;
  logic       bad_cc;

  // Null packets and adaptation-only packets carry no meaningful continuity.
  assign qualify = hdr_stb && (pid == target_pid) && (pid != TS_NULL_PID) && afc_payload;
  assign bad_cc  = seeded && (cc != last_cc) && (cc != last_cc + 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seeded     <= 1'b0;
      last_cc    <= '0;
      cc_err     <= 1'b0;
      cc_err_cnt <= '0;
    end else begin
      cc_err <= 1'b0;
      if (clear) begin
        seeded <= 1'b0;
      end else if (qualify) begin
        if (bad_cc) begin
          cc_err <= 1'b1;
          if (cc_err_cnt != 16'hFFFF) cc_err_cnt <= cc_err_cnt + 16'd1;
        end
        seeded  <= 1'b1;
        last_cc <= cc;
      end
    end
  end

endmodule

// File: rtl/ts_sync_ctrl.sv
// MPEG-TS packet sync FSM (HUNT/VERIFY/LOCK) with header capture.
// Define TS_CC_CHECK_EN to add continuity checking on target_pid.
module ts_sync_ctrl
  import ts_pkg::*;
#(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic [12:0] target_pid,
  output logic        locked,
  output logic        pkt_start,
  output logic [7:0]  byte_idx,
  output logic        hdr_valid,
  output logic [12:0] pid,
  output logic [3:0]  cc,
  output logic        tei,
  output logic [15:0] sync_loss_cnt,
  output logic        cc_err,
  output logic [15:0] cc_err_cnt
);

  localparam int         GOOD_W   = $clog2(LOCK_CNT + 1);
  localparam int         MISS_W   = $clog2(UNLOCK_CNT + 1);
  localparam logic [7:0] LAST_IDX = 8'(TS_PKT_LEN - 1);

  ts_state_e         state;
  logic [GOOD_W-1:0] good;
  logic [MISS_W-1:0] miss;
  logic [7:0]        hdr_b1;
  logic [7:0]        hdr_b2;
  logic [7:0]        idx_next;
  logic [12:0]       pid_new;
  logic              is_sync;
  logic              at_pos0;
  logic              in_lock;
  logic              hdr_stb;
  logic              lock_exit;

  assign idx_next  = (byte_idx == LAST_IDX) ? 8'd0 : byte_idx + 8'd1;
  assign is_sync   = (in_data == TS_SYNC_BYTE);
  assign at_pos0   = (idx_next == 8'd0);
  assign in_lock   = in_valid && (state == LOCK);
  assign hdr_stb   = in_lock && (idx_next == 8'd3);
  assign lock_exit = in_lock && at_pos0 && !is_sync && (int'(miss) + 1 >= UNLOCK_CNT);
  assign pid_new   = {hdr_b1[4:0], hdr_b2};

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // blocking writes would let later statements observe half-updated state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= HUNT;
      good          <= '0;
      miss          <= '0;
      byte_idx      <= '0;
      locked        <= 1'b0;
      pkt_start     <= 1'b0;
      hdr_valid     <= 1'b0;
      hdr_b1        <= '0;
      hdr_b2        <= '0;
      pid           <= '0;
      cc            <= '0;
      tei           <= 1'b0;
      sync_loss_cnt <= '0;
    end else begin
      pkt_start <= 1'b0;
      hdr_valid <= 1'b0;
      if (in_valid) begin
        unique case (state)
          HUNT: begin
            if (is_sync) begin
              state    <= VERIFY;
              byte_idx <= 8'd0;
              good     <= GOOD_W'(1);
            end
          end
          VERIFY: begin
            byte_idx <= idx_next;
            if (at_pos0) begin
              if (!is_sync) begin
                state    <= HUNT;
                good     <= '0;
                byte_idx <= 8'd0;
              end else if (int'(good) + 1 >= LOCK_CNT) begin
                state     <= LOCK;
                locked    <= 1'b1;
                pkt_start <= 1'b1;
                good      <= '0;
                miss      <= '0;
              end else begin
                good <= good + 1'b1;
              end
            end
          end
          LOCK: begin
            if (lock_exit) begin
              state    <= HUNT;
              locked   <= 1'b0;
              good     <= '0;
              miss     <= '0;
              byte_idx <= 8'd0;
              if (sync_loss_cnt != 16'hFFFF) sync_loss_cnt <= sync_loss_cnt + 16'd1;
            end else begin
              byte_idx <= idx_next;
              if (at_pos0) begin
                // Flywheel: a bad sync byte still marks the packet boundary.
                pkt_start <= 1'b1;
                if (is_sync) miss <= '0;
                else         miss <= miss + 1'b1;
              end else begin
                case (idx_next)
                  8'd1: hdr_b1 <= in_data;
                  8'd2: hdr_b2 <= in_data;
                  8'd3: begin
                    tei       <= hdr_b1[7];
                    pid       <= pid_new;
                    cc        <= in_data[3:0];
                    hdr_valid <= 1'b1;
                  end
                  default: ;
                endcase
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef TS_CC_CHECK_EN
  ts_cc_checker u_cc_checker (
    .clk         (clk),
    .rst         (rst),
    .clear       (lock_exit),
    .hdr_stb     (hdr_stb),
    .pid         (pid_new),
    .cc          (in_data[3:0]),
    .afc_payload (in_data[4]),
    .target_pid  (target_pid),
    .cc_err      (cc_err),
    .cc_err_cnt  (cc_err_cnt)
  );
`else
  logic unused_cc_inputs;
  assign unused_cc_inputs = ^{target_pid, hdr_stb};
  assign cc_err     = 1'b0;
  assign cc_err_cnt = '0;
`endif

endmodule

// File: tb/tb_ts_sync_ctrl.sv
// Directed bench for ts_sync_ctrl: reset, lock, flywheel/loss, bubbles,
// continuity (expectations follow TS_CC_CHECK_EN) and mid-packet reset.
`timescale 1ns/1ps
module tb_ts_sync_ctrl;
  import ts_pkg::*;

  typedef struct {
    int starts;
    int hdrs;
    int errs;
    int idx_bad;
    int start_pos;
    int hdr_pos;
    int err_pos;
  } pkt_res_t;

`ifdef TS_CC_CHECK_EN
  localparam int CC_EN = 1;
`else
  localparam int CC_EN = 0;
`endif

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic [7:0]  in_data    = 8'h00;
  logic        in_valid   = 1'b0;
  logic [12:0] target_pid = 13'h100;
  logic        locked;
  logic        pkt_start;
  logic [7:0]  byte_idx;
  logic        hdr_valid;
  logic [12:0] pid;
  logic [3:0]  cc;
  logic        tei;
  logic [15:0] sync_loss_cnt;
  logic        cc_err;
  logic [15:0] cc_err_cnt;

  int errors = 0;
  int checks = 0;
  logic [3:0] cc_seq = 4'd0;

  always #5 clk = ~clk;

  ts_sync_ctrl #(.LOCK_CNT(3), .UNLOCK_CNT(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .target_pid    (target_pid),
    .locked        (locked),
    .pkt_start     (pkt_start),
    .byte_idx      (byte_idx),
    .hdr_valid     (hdr_valid),
    .pid           (pid),
    .cc            (cc),
    .tei           (tei),
    .sync_loss_cnt (sync_loss_cnt),
    .cc_err        (cc_err),
    .cc_err_cnt    (cc_err_cnt)
  );

  // One accepted byte; returns 1 ns after the capturing edge.
  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n, inout pkt_res_t r);
    logic [7:0] held;
    held    = byte_idx;
    in_data = TS_SYNC_BYTE;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (byte_idx !== held || pkt_start !== 1'b0 || hdr_valid !== 1'b0) r.idx_bad++;
    end
  endtask

  task automatic send_pkt(input logic [7:0] sync, input logic [12:0] p, input logic [3:0] c,
                          input logic t, input logic afc1, input int gap_pct, input int nbytes,
                          output pkt_res_t r);
    logic [7:0] b;
    r = '{starts: 0, hdrs: 0, errs: 0, idx_bad: 0, start_pos: -1, hdr_pos: -1, err_pos: -1};
    for (int i = 0; i < nbytes; i++) begin
      case (i)
        0:       b = sync;
        1:       b = {t, 2'b00, p[12:8]};
        2:       b = p[7:0];
        3:       b = {2'b00, (afc1 ? 2'b01 : 2'b10), c};
        default: b = 8'(i) & 8'h3F;
      endcase
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) idle(int'($urandom_range(3, 1)), r);
      send_byte(b);
      if (pkt_start === 1'b1) begin r.starts++; r.start_pos = i; end
      if (hdr_valid === 1'b1) begin r.hdrs++;   r.hdr_pos   = i; end
      if (cc_err    === 1'b1) begin r.errs++;   r.err_pos   = i; end
      if (byte_idx !== 8'(i)) r.idx_bad++;
    end
  endtask

  task automatic send_main(input logic [7:0] sync, input logic t, output pkt_res_t r);
    send_pkt(sync, 13'h100, cc_seq, t, 1'b1, 0, 188, r);
    cc_seq = cc_seq + 4'd1;
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_data  = 8'($urandom);
      in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    checks++;
    if ({locked, pkt_start, hdr_valid, tei, cc_err} !== 5'b0) begin
      errors++; $display("FAIL rst_flags: got %b expected 00000", {locked, pkt_start, hdr_valid, tei, cc_err});
    end
    checks++;
    if (byte_idx !== 8'd0) begin errors++; $display("FAIL rst_byte_idx: got %0d expected 0", byte_idx); end
    checks++;
    if (pid !== 13'd0 || cc !== 4'd0) begin errors++; $display("FAIL rst_hdr: got pid=%0h cc=%0h expected 0", pid, cc); end
    checks++;
    if (sync_loss_cnt !== 16'd0) begin errors++; $display("FAIL rst_loss_cnt: got %0d expected 0", sync_loss_cnt); end
    checks++;
    if (cc_err_cnt !== 16'd0) begin errors++; $display("FAIL rst_cc_err_cnt: got %0d expected 0", cc_err_cnt); end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      send_byte(8'(i) & 8'h3F);
      if (locked !== 1'b0 || pkt_start !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL nosync_activity: got %0d cycles locked/pulsing expected 0", seen); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL nosync_locked: got %b expected 0", locked); end
  endtask

  task automatic test_lock();
    pkt_res_t r;
    send_main(TS_SYNC_BYTE, 1'b0, r);
    checks++;
    if (r.starts !== 0 || r.hdrs !== 0 || r.idx_bad !== 0) begin
      errors++; $display("FAIL lock_p1: got starts=%0d hdrs=%0d idx_bad=%0d expected 0/0/0", r.starts, r.hdrs, r.idx_bad);
    end
    send_main(TS_SYNC_BYTE, 1'b0, r);
    checks++;
    if (locked !== 1'b0 || r.starts !== 0) begin
      errors++; $display("FAIL lock_p2: got locked=%b starts=%0d expected 0/0", locked, r.starts);
    end
    send_main(TS_SYNC_BYTE, 1'b0, r);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL lock_p3_locked: got %b expected 1", locked); end
    checks++;
    if (r.starts !== 1 || r.start_pos !== 0) begin
      errors++; $display("FAIL lock_p3_start: got starts=%0d pos=%0d expected 1 at 0", r.starts, r.start_pos);
    end
    checks++;
    if (r.hdrs !== 1 || r.hdr_pos !== 3) begin
      errors++; $display("FAIL lock_p3_hdr: got hdrs=%0d pos=%0d expected 1 at 3", r.hdrs, r.hdr_pos);
    end
    checks++;
    if (pid !== 13'h100 || cc !== 4'd2 || tei !== 1'b0) begin
      errors++; $display("FAIL lock_p3_fields: got pid=%0h cc=%0d tei=%b expected 100/2/0", pid, cc, tei);
    end
    send_main(TS_SYNC_BYTE, 1'b1, r);
    checks++;
    if (r.starts !== 1 || r.hdrs !== 1 || r.idx_bad !== 0) begin
      errors++; $display("FAIL lock_p4: got starts=%0d hdrs=%0d idx_bad=%0d expected 1/1/0", r.starts, r.hdrs, r.idx_bad);
    end
    checks++;
    if (tei !== 1'b1 || cc !== 4'd3) begin errors++; $display("FAIL lock_p4_fields: got tei=%b cc=%0d expected 1/3", tei, cc); end
  endtask

  task automatic test_flywheel();
    pkt_res_t r;
    logic [7:0] syncs [5] = '{8'h00, 8'hB8, TS_SYNC_BYTE, 8'h00, 8'h46};
    for (int k = 0; k < 5; k++) begin
      send_main(syncs[k], 1'b0, r);
      checks++;
      if (locked !== 1'b1 || r.starts !== 1 || r.start_pos !== 0 || r.hdrs !== 1) begin
        errors++;
        $display("FAIL flywheel_%0d: got locked=%b starts=%0d pos=%0d hdrs=%0d expected 1/1/0/1",
                 k, locked, r.starts, r.start_pos, r.hdrs);
      end
    end
    checks++;
    if (sync_loss_cnt !== 16'd0) begin errors++; $display("FAIL flywheel_loss_cnt: got %0d expected 0", sync_loss_cnt); end
    send_main(8'h00, 1'b0, r);
    checks++;
    if (locked !== 1'b0 || r.starts !== 0 || r.hdrs !== 0) begin
      errors++; $display("FAIL loss_pkt: got locked=%b starts=%0d hdrs=%0d expected 0/0/0", locked, r.starts, r.hdrs);
    end
    checks++;
    if (sync_loss_cnt !== 16'd1) begin errors++; $display("FAIL loss_cnt: got %0d expected 1", sync_loss_cnt); end
  endtask

  task automatic test_bubbles();
    pkt_res_t r;
    for (int k = 0; k < 3; k++) begin
      send_pkt(TS_SYNC_BYTE, 13'h0A5C, 4'(9 + k), 1'b1, 1'b1, 25, 188, r);
      checks++;
      if (r.idx_bad !== 0) begin errors++; $display("FAIL bubble_idx_%0d: got %0d bad samples expected 0", k, r.idx_bad); end
    end
    checks++;
    if (locked !== 1'b1 || r.starts !== 1 || r.start_pos !== 0 || r.hdrs !== 1 || r.hdr_pos !== 3) begin
      errors++;
      $display("FAIL bubble_lock: got locked=%b starts=%0d@%0d hdrs=%0d@%0d expected 1 1@0 1@3",
               locked, r.starts, r.start_pos, r.hdrs, r.hdr_pos);
    end
    checks++;
    if (pid !== 13'h0A5C || cc !== 4'd11 || tei !== 1'b1) begin
      errors++; $display("FAIL bubble_fields_a: got pid=%0h cc=%0d tei=%b expected a5c/11/1", pid, cc, tei);
    end
    send_pkt(TS_SYNC_BYTE, 13'h1234, 4'd4, 1'b0, 1'b1, 25, 188, r);
    checks++;
    if (r.idx_bad !== 0 || r.hdrs !== 1 || r.starts !== 1) begin
      errors++; $display("FAIL bubble_p4: got idx_bad=%0d hdrs=%0d starts=%0d expected 0/1/1", r.idx_bad, r.hdrs, r.starts);
    end
    checks++;
    if (pid !== 13'h1234 || cc !== 4'd4 || tei !== 1'b0) begin
      errors++; $display("FAIL bubble_fields_b: got pid=%0h cc=%0d tei=%b expected 1234/4/0", pid, cc, tei);
    end
  endtask

  task automatic test_cc();
    pkt_res_t r;
    logic [3:0] seq [5] = '{4'd14, 4'd15, 4'd0, 4'd0, 4'd2};
    int exp_errs [5] = '{0, 0, 0, 0, CC_EN};
    int exp_pos;
    exp_pos = (CC_EN == 1) ? 3 : -1;
    target_pid = 13'h100;
    for (int k = 0; k < 5; k++) begin
      send_pkt(TS_SYNC_BYTE, 13'h100, seq[k], 1'b0, 1'b1, 0, 188, r);
      checks++;
      if (r.errs !== exp_errs[k]) begin
        errors++; $display("FAIL cc_seq_%0d: got %0d cc_err pulses expected %0d", k, r.errs, exp_errs[k]);
      end
    end
    checks++;
    if (r.err_pos !== exp_pos) begin errors++; $display("FAIL cc_err_align: got pulse at %0d expected %0d", r.err_pos, exp_pos); end
    checks++;
    if (cc_err_cnt !== 16'(CC_EN)) begin errors++; $display("FAIL cc_err_cnt: got %0d expected %0d", cc_err_cnt, CC_EN); end
    send_pkt(TS_SYNC_BYTE, 13'h200, 4'd7, 1'b0, 1'b1, 0, 188, r);
    checks++;
    if (r.errs !== 0) begin errors++; $display("FAIL cc_other_pid: got %0d errors expected 0", r.errs); end
    send_pkt(TS_SYNC_BYTE, 13'h100, 4'd9, 1'b0, 1'b0, 0, 188, r);
    checks++;
    if (r.errs !== 0) begin errors++; $display("FAIL cc_no_payload: got %0d errors expected 0", r.errs); end
    send_pkt(TS_SYNC_BYTE, 13'h100, 4'd3, 1'b0, 1'b1, 0, 188, r);
    checks++;
    if (r.errs !== 0) begin errors++; $display("FAIL cc_after_skip: got %0d errors expected 0", r.errs); end
    target_pid = TS_NULL_PID;
    send_pkt(TS_SYNC_BYTE, TS_NULL_PID, 4'd5, 1'b0, 1'b1, 0, 188, r);
    send_pkt(TS_SYNC_BYTE, TS_NULL_PID, 4'd11, 1'b0, 1'b1, 0, 188, r);
    checks++;
    if (r.errs !== 0 || cc_err_cnt !== 16'(CC_EN)) begin
      errors++; $display("FAIL cc_null_pid: got errs=%0d cnt=%0d expected 0/%0d", r.errs, cc_err_cnt, CC_EN);
    end
    target_pid = 13'h100;
  endtask

  task automatic test_reset_mid();
    pkt_res_t r;
    send_pkt(TS_SYNC_BYTE, 13'h100, 4'd4, 1'b0, 1'b1, 0, 51, r);
    @(negedge clk);
    rst      = 1'b0;
    in_data  = TS_SYNC_BYTE;
    in_valid = 1'b1;
    #1;
    checks++;
    if (locked !== 1'b0 || byte_idx !== 8'd0 || pid !== 13'd0) begin
      errors++; $display("FAIL mid_rst_state: got locked=%b idx=%0d pid=%0h expected 0/0/0", locked, byte_idx, pid);
    end
    checks++;
    if (sync_loss_cnt !== 16'd0 || cc_err_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_rst_counts: got loss=%0d cc_err_cnt=%0d expected 0/0", sync_loss_cnt, cc_err_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    cc_seq   = 4'd0;
    send_main(TS_SYNC_BYTE, 1'b0, r);
    checks++;
    if (r.idx_bad !== 0 || r.starts !== 0) begin
      errors++; $display("FAIL relock_p1: got idx_bad=%0d starts=%0d expected 0/0", r.idx_bad, r.starts);
    end
    send_main(TS_SYNC_BYTE, 1'b0, r);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL relock_p2: got locked=%b expected 0", locked); end
    send_main(TS_SYNC_BYTE, 1'b0, r);
    checks++;
    if (locked !== 1'b1 || r.starts !== 1 || r.start_pos !== 0) begin
      errors++; $display("FAIL relock_p3: got locked=%b starts=%0d@%0d expected 1 1@0", locked, r.starts, r.start_pos);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time budget, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_lock();
    test_flywheel();
    test_bubbles();
    test_cc();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
